// File: rtl/phase_pulse_gen_pkg.sv
// Shared definitions for the phase pulse generator: FSM encoding and defaults.
package phase_pulse_gen_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int NS_PER_CLK_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/phase_pulse_gen_chan.sv
// One pulse channel: free-running period counter with registered output.
// Starts at count 0 on 'start'; with stop_req set it halts at the end of the
// current period, so a pulse is never cut short.
module phase_pulse_gen_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop_req,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic             out,
    output logic             done
);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             run, run_nxt;

    // Next counter/run state; start has priority over a pending stop.
    always_comb begin
        cnt_nxt = cnt;
        run_nxt = run;
        if (start) begin
            cnt_nxt = '0;
            run_nxt = 1'b1;
        end else if (run) begin
            if (cnt == period - CNT_W'(1)) begin
                cnt_nxt = '0;
                run_nxt = !stop_req;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Output is registered from the next-state compare, so it has no extra lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            run <= 1'b0;
            out <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            run <= run_nxt;
            out <= run_nxt && (cnt_nxt < high);
        end
    end

    assign done = !run;

endmodule

// File: rtl/phase_pulse_gen.sv
// Two-channel pulse generator: channel 1 repeats channel 0 delayed by
// delay_cyc clocks. Holds config, validation, run/drain FSM and the ch1 start delay.
module phase_pulse_gen
    import phase_pulse_gen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int NS_PER_CLK = NS_PER_CLK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] period_cyc,
    input  logic [CNT_W-1:0] high_cyc,
    input  logic [CNT_W-1:0] delay_cyc,
    input  logic             enable,
    output logic             cfg_err,
    output logic             busy,
    output logic [CNT_W-1:0] delay_ns,
    output logic             sig_out,
    output logic             sig_out1
);

    localparam logic [CNT_W-1:0] NS_K = CNT_W'(NS_PER_CLK);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] act_period, act_high, act_delay;
    logic [CNT_W-1:0] dly_cnt;
    logic             dly_pend;
    logic             in_ok, act_ok, accept;
    logic             start0, start1, stop_req, running;
    logic             done0, done1;

    assign in_ok  = (period_cyc >= CNT_W'(2)) && (high_cyc != '0) &&
                    (high_cyc < period_cyc) && (delay_cyc < period_cyc);
    assign act_ok = (act_period >= CNT_W'(2)) && (act_high != '0) &&
                    (act_high < act_period) && (act_delay < act_period);

    assign cfg_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cfg_valid && cfg_ready;
    assign running   = (state == ST_RUN) && enable;
    assign stop_req  = !running;

    // Active config: only replaced by a valid offer; a bad offer flags cfg_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period <= '0;
            act_high   <= '0;
            act_delay  <= '0;
            cfg_err    <= 1'b0;
            delay_ns   <= '0;
        end else begin
            if (accept && in_ok) begin
                act_period <= period_cyc;
                act_high   <= high_cyc;
                act_delay  <= delay_cyc;
            end
            cfg_err  <= accept && !in_ok;
            delay_ns <= act_delay * NS_K;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and channel start pulses.
    always_comb begin
        state_nxt = state;
        start0    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && act_ok) begin
                    state_nxt = ST_RUN;
                    start0    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (done0 && done1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        start1 = (start0 && (act_delay == '0)) ||
                 (running && dly_pend && (dly_cnt == CNT_W'(1)));
    end

    // Ch1 start delay; a pending start is dropped once enable falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt  <= '0;
            dly_pend <= 1'b0;
        end else if (start0) begin
            dly_cnt  <= act_delay;
            dly_pend <= (act_delay != '0);
        end else if (running && dly_pend) begin
            if (dly_cnt == CNT_W'(1)) dly_pend <= 1'b0;
            else                      dly_cnt  <= dly_cnt - CNT_W'(1);
        end else if (!running) begin
            dly_pend <= 1'b0;
        end
    end

    phase_pulse_gen_chan #(.CNT_W(CNT_W)) u_ch0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start0),
        .stop_req (stop_req),
        .period   (act_period),
        .high     (act_high),
        .out      (sig_out),
        .done     (done0)
    );

    phase_pulse_gen_chan #(.CNT_W(CNT_W)) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .stop_req (stop_req),
        .period   (act_period),
        .high     (act_high),
        .out      (sig_out1),
        .done     (done1)
    );

endmodule
